// File: rtl/unified_memory.sv
// RAM plus MMIO window behind the RV32I core's memory bus: RV32I load/store sizing,
// one-cycle registered read, LED/cycle-counter/misaligned-status registers.
module unified_memory #(
  parameter int          DEPTH_WORDS = 2048,
  parameter              INIT_FILE   = "",
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_ra,
  input  logic [2:0]  mem_funct3,
  input  logic        mem_wen,
  input  logic [31:0] mem_wa,
  input  logic [31:0] mem_wd,
  output logic [31:0] mem_rd,
  output logic [7:0]  led,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] ram [DEPTH_WORDS];
  logic [31:0] cycle_cnt;

  function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b001, 3'b101: return a[0];
      3'b010:         return a != 2'b00;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] a);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] sx;
    b  = w[{a, 3'b000} +: 8];
    h  = a[1] ? w[31:16] : w[15:0];
    sb = signed'(b);
    sh = signed'(h);
    case (f3)
      3'b000:  begin sx = sb; return unsigned'(sx); end
      3'b001:  begin sx = sh; return unsigned'(sx); end
      3'b010:  return w;
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return 32'b0;
    endcase
  endfunction

  // Stage p0: decode, sizing and read-word selection
  logic          rd_mmio_p0, wr_mmio_p0;
  logic [AW-1:0] ridx_p0, widx_p0;
  logic          rd_mis_p0, wr_mis_p0;
  logic [3:0]    be_raw_p0, be_p0;
  logic [31:0]   wsh_p0, mmio_word_p0, rword_p0;
  logic          store_p0, ram_we_p0, led_we_p0, cnt_clr_p0, st_clr_p0, mis_set_p0;

  assign rd_mmio_p0 = mem_ra[31:16] == MMIO_BASE[31:16];
  assign wr_mmio_p0 = mem_wa[31:16] == MMIO_BASE[31:16];
  assign ridx_p0    = mem_ra[AW+1:2];
  assign widx_p0    = mem_wa[AW+1:2];
  assign rd_mis_p0  = access_misaligned(mem_funct3, mem_ra[1:0]);

  always_comb begin
    be_raw_p0 = 4'b0000;
    wsh_p0    = 32'b0;
    case (mem_funct3)
      3'b000: begin be_raw_p0 = 4'b0001 << mem_wa[1:0];            wsh_p0 = {4{mem_wd[7:0]}};  end
      3'b001: begin be_raw_p0 = mem_wa[1] ? 4'b1100 : 4'b0011;     wsh_p0 = {2{mem_wd[15:0]}}; end
      3'b010: begin be_raw_p0 = 4'b1111;                           wsh_p0 = mem_wd;            end
      default: ;
    endcase
  end

  assign wr_mis_p0  = mem_wen && (be_raw_p0 != 4'b0000) && access_misaligned(mem_funct3, mem_wa[1:0]);
  assign store_p0   = mem_wen && (be_raw_p0 != 4'b0000) && !wr_mis_p0;
  assign be_p0      = store_p0 ? be_raw_p0 : 4'b0000;
  assign ram_we_p0  = store_p0 && !wr_mmio_p0;
  assign led_we_p0  = store_p0 && wr_mmio_p0 && (mem_wa[15:0] == 16'h0000) &&
                      (mem_funct3 == 3'b000 || mem_funct3 == 3'b010);
  assign cnt_clr_p0 = store_p0 && wr_mmio_p0 && (mem_wa[15:2] == 14'd1);
  assign st_clr_p0  = store_p0 && wr_mmio_p0 && (mem_wa[15:2] == 14'd2) && be_p0[0] && wsh_p0[0];
  assign mis_set_p0 = rd_mis_p0 || wr_mis_p0;

  always_comb begin
    mmio_word_p0 = 32'b0;
    case (mem_ra[15:2])
      14'd0:   mmio_word_p0 = {24'b0, led};
      14'd1:   mmio_word_p0 = cycle_cnt;
      14'd2:   mmio_word_p0 = {31'b0, misaligned};
      default: mmio_word_p0 = 32'b0;
    endcase
  end

  assign rword_p0 = rd_mmio_p0 ? mmio_word_p0 : ram[ridx_p0];

  // Stage p1: registered read data, MMIO state and RAM commit.
  // The RAM write lives in the reset branch's else so a store sampled with reset high is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rd     <= 32'b0;
      led        <= 8'b0;
      cycle_cnt  <= 32'b0;
      misaligned <= 1'b0;
    end else begin
      mem_rd    <= rd_mis_p0 ? 32'b0 : lane_extract(rword_p0, mem_funct3, mem_ra[1:0]);
      if (led_we_p0) led <= mem_wd[7:0];
      cycle_cnt <= cnt_clr_p0 ? 32'b0 : cycle_cnt + 32'd1;
      if (mis_set_p0)     misaligned <= 1'b1;
      else if (st_clr_p0) misaligned <= 1'b0;
      if (ram_we_p0) begin
        for (int i = 0; i < 4; i++) begin
          if (be_p0[i]) ram[widx_p0][8*i +: 8] <= wsh_p0[8*i +: 8];
        end
      end
    end
  end

endmodule
